// File: rtl/bram_loader.sv
// bram_loader: streams 32-bit message words into 512-bit rows of a downstream
// memory. Each accepted word is written one cycle later as one 32-bit slice of
// the current row, with the most significant slice written first.
// A job is started by a start pulse and can be cancelled with abort.
// Optional build macro: BRAM_LOADER_BYTE_SWAP_EN. When it is defined, each word
// is byte-reversed before it is written. When it is undefined, words pass
// through unchanged.
module bram_loader #(
  parameter int BRAM_DEPTH = 500
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] num_blocks,
  input  logic        abort,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [15:0] addr,
  output logic [8:0]  addr_width,
  output logic        cs_n,
  output logic        wr_n,
  output logic        rd_n,
  output logic [31:0] bram_data_in,
  output logic        block_done,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Each row holds a fixed 16 words of 32 bits.
  localparam int WORDS_PER_ROW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  k_reg;         // word index within the current row
  logic [15:0] row_reg;       // row currently being filled
  logic [15:0] last_row_reg;  // final row of the job

  logic [16:0] end_excl;      // base_addr + num_blocks, kept 17-bit so it cannot wrap
  logic        start_ok;
  logic        xfer;
  logic        last_word;
  logic [31:0] word_mapped;

  // The memory is write-only from this block, so the read strobe stays idle.
  assign rd_n = 1'b1;

  assign end_excl  = {1'b0, base_addr} + {1'b0, num_blocks};
  assign start_ok  = (num_blocks != 16'd0) && (end_excl <= 17'(BRAM_DEPTH));
  // word_ready is only ever high in LOAD, so the handshake alone identifies a transfer.
  assign xfer      = word_valid && word_ready;
  assign last_word = (k_reg == 4'(WORDS_PER_ROW - 1));

`ifdef BRAM_LOADER_BYTE_SWAP_EN
  // Byte-reverse each word. This is only a wire permutation, so it adds no logic and no delay.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_swap
      assign word_mapped[8*gi +: 8] = word_in[8*(3-gi) +: 8];
    end
  endgenerate
`else
  assign word_mapped = word_in;
`endif

  // Job control FSM and the registered write port. A word accepted on an edge
  // is presented to the memory for exactly the following cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      k_reg        <= 4'd0;
      row_reg      <= 16'd0;
      last_row_reg <= 16'd0;
      word_ready   <= 1'b0;
      addr         <= 16'd0;
      addr_width   <= 9'd511;
      bram_data_in <= 32'd0;
      cs_n         <= 1'b1;
      wr_n         <= 1'b1;
      block_done   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // Strobes and pulses are idle unless this cycle's logic raises them.
      cs_n       <= 1'b1;
      wr_n       <= 1'b1;
      block_done <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;

      // A handshake that completes on this edge is always honoured, even if
      // abort arrives on the same edge. The accepted word is still written.
      if (xfer) begin
        cs_n         <= 1'b0;
        wr_n         <= 1'b0;
        addr         <= row_reg;
        addr_width   <= 9'd511 - {k_reg, 5'b00000};
        bram_data_in <= word_mapped;
        block_done   <= last_word;
      end

      case (state_reg)
        IDLE: begin
          // If abort and start arrive together, abort wins and the start is dropped silently.
          if (start && !abort) begin
            if (start_ok) begin
              state_reg    <= LOAD;
              row_reg      <= base_addr;
              last_row_reg <= base_addr + num_blocks - 16'd1;
              k_reg        <= 4'd0;
              busy         <= 1'b1;
              word_ready   <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (abort) begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            word_ready <= 1'b0;
          end else if (xfer) begin
            k_reg <= k_reg + 4'd1;
            if (last_word) begin
              if (row_reg == last_row_reg) begin
                // Stop accepting words. The final write happens during FINISH.
                state_reg  <= FINISH;
                word_ready <= 1'b0;
              end else begin
                row_reg <= row_reg + 16'd1;
              end
            end
          end
        end

        FINISH: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= !abort;
        end

        default: begin
          state_reg  <= IDLE;
          busy       <= 1'b0;
          word_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: directed test of bram_loader.
// A negedge monitor logs every write strobe and every handshake.
// Each scenario then compares the logged writes with hand-computed values.
module tb_bram_loader;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] num_blocks = 16'd0;
  logic        abort = 1'b0;
  logic [31:0] word_in = 32'd0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [15:0] addr;
  logic [8:0]  addr_width;
  logic        cs_n;
  logic        wr_n;
  logic        rd_n;
  logic [31:0] bram_data_in;
  logic        block_done;
  logic        busy;
  logic        done;
  logic        err;

  bram_loader #(.BRAM_DEPTH(500)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_blocks(num_blocks), .abort(abort), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .addr(addr),
    .addr_width(addr_width), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .bram_data_in(bram_data_in), .block_done(block_done), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] w);
`ifdef BRAM_LOADER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Monitor: log writes, handshakes and pulses, sampled away from the active edge.
  int          cyc = 0;
  logic [15:0] w_addr [256];
  logic [8:0]  w_aw   [256];
  logic [31:0] w_data [256];
  logic        w_bd   [256];
  int          w_cyc  [256];
  int          x_cyc  [256];
  int          nw = 0, nx = 0, n_done = 0, n_err = 0, done_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (word_valid && word_ready && nx < 256) begin
      x_cyc[nx] = cyc + 1;
      nx++;
    end
    if (!cs_n && !wr_n && nw < 256) begin
      w_addr[nw] = addr;
      w_aw[nw]   = addr_width;
      w_data[nw] = bram_data_in;
      w_bd[nw]   = block_done;
      w_cyc[nw]  = cyc;
      nw++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err) n_err++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_blocks = n;
    step();
    start = 1'b0;
  endtask

  // Offer one word, wait (bounded) for it to be accepted, then idle for 'gap' cycles.
  task automatic send(input logic [31:0] w, input int gap);
    int t = 0;
    word_in = w; word_valid = 1'b1;
    while (!word_ready && t < 50) begin
      step();
      t++;
    end
    if (!word_ready) check("ready_timeout", {31'd0, word_ready}, 32'd1);
    else step();
    word_valid = 1'b0;
    repeat (gap) step();
  endtask

  initial begin
    int w0, x0, d0, e0;

    // ---- reset values ----
    rst_n = 1'b0;
    step(); step();
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_wr_n", {31'd0, wr_n}, 32'd1);
    check("rst_rd_n", {31'd0, rd_n}, 32'd1);
    check("rst_addr", {16'd0, addr}, 32'd0);
    check("rst_aw", {23'd0, addr_width}, 32'd511);
    check("rst_data", bram_data_in, 32'd0);
    check("rst_ready", {31'd0, word_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {29'd0, done, err, block_done}, 32'd0);
    rst_n = 1'b1;
    step();

    // ---- A: one row at address 0, back-to-back words ----
    w0 = nw; d0 = n_done;
    pulse_start(16'd0, 16'd1);
    check("A_busy", {31'd0, busy}, 32'd1);
    check("A_ready", {31'd0, word_ready}, 32'd1);
    start = 1'b1; num_blocks = 16'd0;          // bad start while busy: ignored
    step();
    start = 1'b0;
    check("A_busy_start_no_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 16; i++) send(32'(i), 0);
    repeat (3) step();
    check("A_nwrites", 32'(nw - w0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("A_addr%0d", i), {16'd0, w_addr[w0+i]}, 32'd0);
      check($sformatf("A_aw%0d", i), {23'd0, w_aw[w0+i]}, 32'(511 - 32*i));
      check($sformatf("A_data%0d", i), w_data[w0+i], exp_data(32'(i)));
      check($sformatf("A_bd%0d", i), {31'd0, w_bd[w0+i]}, (i == 15) ? 32'd1 : 32'd0);
    end
    check("A_done_count", 32'(n_done - d0), 32'd1);
    check("A_done_lat", 32'(done_cyc), 32'(w_cyc[w0+15] + 1));

    // ---- B: range check at the top of memory ----
    w0 = nw; e0 = n_err;
    pulse_start(16'd498, 16'd3);
    check("B_err", {31'd0, err}, 32'd1);
    check("B_busy", {31'd0, busy}, 32'd0);
    step();
    check("B_err_pulse", {31'd0, err}, 32'd0);
    pulse_start(16'd0, 16'd0);
    check("B_err_zero", {31'd0, err}, 32'd1);
    repeat (2) step();
    check("B_nwrites_rej", 32'(nw - w0), 32'd0);
    check("B_err_count", 32'(n_err - e0), 32'd2);
    w0 = nw; d0 = n_done;
    pulse_start(16'd498, 16'd2);
    check("B_busy_ok", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 32; i++) send(32'h100 + 32'(i), 0);
    repeat (3) step();
    check("B_nwrites", 32'(nw - w0), 32'd32);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("B_addr%0d", i), {16'd0, w_addr[w0+i]}, 32'(498 + i/16));
      check($sformatf("B_data%0d", i), w_data[w0+i], exp_data(32'h100 + 32'(i)));
    end
    check("B_done_count", 32'(n_done - d0), 32'd1);

    // ---- C: two rows, word_valid every other cycle ----
    w0 = nw; x0 = nx; d0 = n_done;
    pulse_start(16'd0, 16'd2);
    for (int i = 0; i < 32; i++) send(32'hA000 + 32'(i), 1);
    repeat (3) step();
    check("C_nwrites", 32'(nw - w0), 32'd32);
    check("C_nxfers", 32'(nx - x0), 32'd32);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("C_lat%0d", i), 32'(w_cyc[w0+i]), 32'(x_cyc[x0+i]));
      check($sformatf("C_addr%0d", i), {16'd0, w_addr[w0+i]}, (i < 16) ? 32'd0 : 32'd1);
      check($sformatf("C_aw%0d", i), {23'd0, w_aw[w0+i]}, 32'(511 - 32*(i % 16)));
    end
    check("C_done_count", 32'(n_done - d0), 32'd1);

    // ---- D: abort after word 5, then a clean job ----
    w0 = nw; d0 = n_done;
    pulse_start(16'd10, 16'd1);
    for (int i = 0; i < 6; i++) send(32'hD0 + 32'(i), 0);
    abort = 1'b1;
    check("D_w5_strobe", {31'd0, cs_n}, 32'd0);
    step();
    abort = 1'b0;
    check("D_busy", {31'd0, busy}, 32'd0);
    check("D_ready", {31'd0, word_ready}, 32'd0);
    word_in = 32'hDEAD; word_valid = 1'b1;
    repeat (3) step();
    word_valid = 1'b0;
    step();
    check("D_nwrites", 32'(nw - w0), 32'd6);
    check("D_last_aw", {23'd0, w_aw[w0+5]}, 32'd351);
    check("D_last_data", w_data[w0+5], exp_data(32'hD5));
    check("D_last_addr", {16'd0, w_addr[w0+5]}, 32'd10);
    check("D_no_done", 32'(n_done - d0), 32'd0);
    abort = 1'b1; start = 1'b1; base_addr = 16'd0; num_blocks = 16'd1;
    step();
    abort = 1'b0; start = 1'b0;
    check("D_abort_wins_busy", {31'd0, busy}, 32'd0);
    check("D_abort_wins_err", {31'd0, err}, 32'd0);
    w0 = nw; d0 = n_done;
    pulse_start(16'd5, 16'd1);
    for (int i = 0; i < 16; i++) send(32'hE0 + 32'(i), 0);
    repeat (3) step();
    check("D2_nwrites", 32'(nw - w0), 32'd16);
    check("D2_addr", {16'd0, w_addr[w0+15]}, 32'd5);
    check("D2_bd", {31'd0, w_bd[w0+15]}, 32'd1);
    check("D2_done_count", 32'(n_done - d0), 32'd1);

    // ---- E: data mapping, then asynchronous reset mid-row ----
    pulse_start(16'd7, 16'd1);
    send(32'h11223344, 0);
    check("E_data", bram_data_in, exp_data(32'h11223344));
    check("E_addr", {16'd0, addr}, 32'd7);
    word_in = 32'h55667788; word_valid = 1'b1;
    step();
    check("E_pending_strobe", {31'd0, wr_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("E_rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("E_rst_wr_n", {31'd0, wr_n}, 32'd1);
    check("E_rst_addr", {16'd0, addr}, 32'd0);
    check("E_rst_aw", {23'd0, addr_width}, 32'd511);
    check("E_rst_data", bram_data_in, 32'd0);
    check("E_rst_busy_ready", {30'd0, busy, word_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    w0 = nw;
    repeat (4) step();
    word_valid = 1'b0;
    check("E_no_write_after_rst", 32'(nw - w0), 32'd0);
    check("E_idle_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 Parameter BRAM_DEPTH, default 500, number of 512-bit rows in the downstream memory.
REQ-002 Parameter WORDS_PER_ROW, default 16, 32-bit words per 512-bit row; fixed, not overridable.
REQ-003 clock  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load job.
REQ-006 base_addr  input  16  first row to write; sampled on accepted start.
REQ-007 num_blocks  input  16  rows to fill; sampled on accepted start.
REQ-008 abort  input  1  synchronous job cancel.
REQ-009 word_in  input  32  incoming message word.
REQ-010 word_valid  input  1  word_in is valid.
REQ-011 word_ready  output  1  loader accepts word_in this cycle.
REQ-012 addr  output  16  memory row address.
REQ-013 addr_width  output  9  top bit index of the 32-bit slice being written.
REQ-014 cs_n, wr_n, rd_n  output  1 each  memory strobes, active-low.
REQ-015 bram_data_in  output  32  word to the memory.
REQ-016 block_done  output  1  one-cycle pulse when a row's last word is written.
REQ-017 busy / done / err  output  1 each  job active / one-cycle completion pulse / one-cycle rejection pulse.

Function
REQ-018 FSM states IDLE, LOAD, FINISH; start in IDLE moves to LOAD only if num_blocks != 0 and base_addr + num_blocks <= BRAM_DEPTH, computed 17-bit with no wrap.
REQ-019 A start that violates REQ-018 pulses err for 1 cycle, and the FSM stays in IDLE.
REQ-020 start while busy is ignored, with no err.
REQ-021 word_ready = 1 only in LOAD; a word transfers when word_valid and word_ready are both 1 on a clock edge.
REQ-022 Write latency is 1 cycle: the cycle after a transfer drives cs_n=0, wr_n=0, addr=current row, addr_width=511-32*k (k = word index 0..15, so 511,479,...,31), bram_data_in=word.
REQ-023 In all other cycles cs_n=1 and wr_n=1; rd_n is held at 1.
REQ-024 Word index k increments per transfer; after k=15, k returns to 0, the row increments, and block_done pulses together with that write strobe.
REQ-025 After the last word of row base_addr+num_blocks-1 is transferred, the FSM enters FINISH with word_ready=0; the final write occurs in FINISH.
REQ-026 FINISH pulses done for 1 cycle and returns to IDLE; busy=1 in LOAD and FINISH.
REQ-027 Stalls: word_valid=0 in LOAD holds k and the row, and writes nothing.
REQ-028 abort in LOAD or FINISH returns the FSM to IDLE next cycle, with no done and no further transfers; a write strobe for a word already transferred still completes.
REQ-029 abort and start in the same IDLE cycle: abort wins and the start is dropped.
REQ-030 Rows never wrap past BRAM_DEPTH-1, as guaranteed by REQ-018.

Reset
REQ-031 When rst_n=0: FSM=IDLE, k=0, row=0, addr=0, addr_width=511, bram_data_in=0, cs_n=wr_n=rd_n=1, and word_ready, block_done, busy, done, err all 0.
REQ-032 Reset mid-job discards the job; after reset release, no write occurs until a new accepted start.

Configuration
REQ-033 Macro BRAM_LOADER_BYTE_SWAP_EN: when defined, bram_data_in = byte-reversed word_in ({b0,b1,b2,b3}); when undefined, bram_data_in = word_in unchanged, with no added logic or latency in either case.

Verification
REQ-034 Reset, then start with base_addr=0, num_blocks=1, and words 0x00000000..0x0000000F back-to-back -> 16 writes to addr 0 with addr_width 511..31, block_done on the 16th write, done 1 cycle later.
REQ-035 start with base_addr=498, num_blocks=3 -> err pulse, busy stays 0, no strobes; base_addr=498, num_blocks=2 -> accepted, rows 498 and 499 written.
REQ-036 num_blocks=2 with word_valid toggling every other cycle -> 32 writes, each exactly 1 cycle after its transfer, row changes 0->1 after word 16, done once.
REQ-037 abort after word 5 of row 0 -> word 5 is written, FSM returns to IDLE, word_ready=0, done never asserts; a new start works normally.
REQ-038 rst_n low mid-row -> all outputs at reset values asynchronously; with BRAM_LOADER_BYTE_SWAP_EN defined, word 0x11223344 writes 0x44332211.
